// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-side types and constants for the PC sequencer and its next-PC mux.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    J   = 2'd2,
    JR  = 2'd3
  } next_sel_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_PC_LIMIT = 32'd32764;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/hazard-side redirect inputs and fetch-side status outputs of the sequencer.
interface pc_sequencer_if;

  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] instr_count;

  modport master (
    input  stall, branch_taken, branch_offset, jump, jump_target, jr, jr_addr,
    output pc, pc_plus4, fetch_valid, halted, misalign_err, instr_count
  );

  modport slave (
    output stall, branch_taken, branch_offset, jump, jump_target, jr, jr_addr,
    input  pc, pc_plus4, fetch_valid, halted, misalign_err, instr_count
  );

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC selection (jr > jump > branch > sequential) with range/alignment flags.
module pc_next_mux
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] PC_LIMIT = DEFAULT_PC_LIMIT
) (
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic [31:0] next_pc,
  output next_sel_t   sel,
  output logic        out_of_range,
  output logic        misaligned
);

  always_comb begin
    sel     = SEQ;
    next_pc = pc_plus4;
    if (jr) begin
      sel     = JR;
      next_pc = jr_addr;
    end else if (jump) begin
      sel     = J;
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (branch_taken) begin
      // Offset is in words; the add wraps modulo 2^32 by design.
      sel     = BR;
      next_pc = pc_plus4 + (branch_offset << 2);
    end
  end

  assign out_of_range = (next_pc >= PC_LIMIT);
  assign misaligned   = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// MIPS fetch PC sequencer: boot cycle, stall freeze, redirects and sticky halt on bad targets.
module pc_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_LIMIT = DEFAULT_PC_LIMIT
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  seq_state_t  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] pc_plus4_reg, pc_plus4_next;
  logic        fetch_valid_reg, fetch_valid_next;
  logic        halted_reg, halted_next;
  logic        misalign_reg, misalign_next;
  logic [31:0] count_reg, count_next;

  logic [31:0] mux_next_pc;
  next_sel_t   mux_sel;
  logic        mux_out_of_range;
  logic        mux_misaligned;

  pc_next_mux #(
    .PC_LIMIT (PC_LIMIT)
  ) u_mux (
    .pc_plus4      (pc_plus4_reg),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .jr            (bus.jr),
    .jr_addr       (bus.jr_addr),
    .next_pc       (mux_next_pc),
    .sel           (mux_sel),
    .out_of_range  (mux_out_of_range),
    .misaligned    (mux_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      pc_plus4_reg    <= RESET_PC + PC_INC;
      fetch_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
      misalign_reg    <= 1'b0;
      count_reg       <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pc_plus4_reg    <= pc_plus4_next;
      fetch_valid_reg <= fetch_valid_next;
      halted_reg      <= halted_next;
      misalign_reg    <= misalign_next;
      count_reg       <= count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pc_plus4_next    = pc_plus4_reg;
    fetch_valid_next = fetch_valid_reg;
    halted_next      = halted_reg;
    misalign_next    = misalign_reg;
    count_next       = count_reg;

    case (state_reg)
      BOOT: begin
        state_next       = RUN;
        fetch_valid_next = 1'b1;
      end
      RUN: begin
        if (bus.stall) begin
          state_next       = STALL;
          fetch_valid_next = 1'b0;
        end else begin
          if (count_reg != 32'hFFFF_FFFF)
            count_next = count_reg + 32'd1;
          if (mux_misaligned || mux_out_of_range) begin
            state_next       = HALT;
            fetch_valid_next = 1'b0;
            halted_next      = 1'b1;
            misalign_next    = mux_misaligned;
          end else begin
            fetch_valid_next = 1'b1;
            pc_next          = mux_next_pc;
            pc_plus4_next    = (mux_sel == SEQ) ? (pc_plus4_reg + PC_INC)
                                                : (mux_next_pc + PC_INC);
          end
        end
      end
      STALL: begin
        // The frozen PC is re-issued as a valid fetch once the stall lifts.
        if (!bus.stall) begin
          state_next       = RUN;
          fetch_valid_next = 1'b1;
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign bus.pc           = pc_reg;
  assign bus.pc_plus4     = pc_plus4_reg;
  assign bus.fetch_valid  = fetch_valid_reg;
  assign bus.halted       = halted_reg;
  assign bus.misalign_err = misalign_reg;
  assign bus.instr_count  = count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: boot, redirects, stall, halt and async reset.
module tb_pc_sequencer;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  pc_sequencer_if bus();

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .PC_LIMIT (32'd32764)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string what);
    @(posedge clk);
    #1;
    $display("%-14s pc=%h pc4=%h fv=%0b halt=%0b mis=%0b cnt=%0d", what, bus.pc,
             bus.pc_plus4, bus.fetch_valid, bus.halted, bus.misalign_err, bus.instr_count);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc"},   bus.pc,           32'h0);
    check({tag, ".pc4"},  bus.pc_plus4,     32'h4);
    check({tag, ".fv"},   bus.fetch_valid,  32'h0);
    check({tag, ".halt"}, bus.halted,       32'h0);
    check({tag, ".mis"},  bus.misalign_err, 32'h0);
    check({tag, ".cnt"},  bus.instr_count,  32'h0);
  endtask

  task automatic clear_redirects;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 32'h0;
    bus.jump          = 1'b0;
    bus.jump_target   = 26'h0;
    bus.jr            = 1'b0;
    bus.jr_addr       = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_redirects();
    #12;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot.pc0", bus.pc, 32'h0);
    check("boot.fv0", bus.fetch_valid, 32'h0);

    // Reset release, sequential fetch
    step("boot");
    check("seq.pc1", bus.pc, 32'h0);
    check("seq.fv1", bus.fetch_valid, 32'h1);
    step("seq");
    check("seq.pc2", bus.pc, 32'h4);
    step("seq");
    check("seq.pc3", bus.pc, 32'h8);
    step("seq");
    check("seq.pc4", bus.pc, 32'hC);
    check("seq.fv4", bus.fetch_valid, 32'h1);
    step("seq");
    check("seq.pc5", bus.pc, 32'h10);
    check("seq.pc4_5", bus.pc_plus4, 32'h14);
    check("seq.cnt5", bus.instr_count, 32'd4);

    // Branch backwards from 0x40
    bus.jr = 1'b1; bus.jr_addr = 32'h40;
    step("jr");
    check("jr.pc40", bus.pc, 32'h40);
    clear_redirects();
    bus.branch_taken = 1'b1; bus.branch_offset = 32'hFFFF_FFFC;
    step("branch");
    check("br.pc34", bus.pc, 32'h34);
    check("br.pc4", bus.pc_plus4, 32'h38);

    // Jump beats branch
    clear_redirects();
    bus.jr = 1'b1; bus.jr_addr = 32'h40;
    step("jr");
    clear_redirects();
    bus.branch_taken = 1'b1; bus.branch_offset = 32'hFFFF_FFFC;
    bus.jump = 1'b1; bus.jump_target = 26'h10;
    step("jump+branch");
    check("jmp.pc40", bus.pc, 32'h40);
    check("jmp.pc4", bus.pc_plus4, 32'h44);

    // Stall at 0x20 with jr held
    clear_redirects();
    bus.jr = 1'b1; bus.jr_addr = 32'h20;
    step("jr");
    check("stl.pc20", bus.pc, 32'h20);
    bus.stall = 1'b1; bus.jr_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check("stl.hold_pc", bus.pc, 32'h20);
      check("stl.fv", bus.fetch_valid, 32'h0);
    end
    bus.stall = 1'b0;
    step("stall_exit");
    check("stl.exit_pc", bus.pc, 32'h20);
    check("stl.exit_fv", bus.fetch_valid, 32'h1);
    step("jr");
    check("stl.jr_pc", bus.pc, 32'h100);
    check("stl.cnt", bus.instr_count, 32'd10);

    // Async reset while stalled
    clear_redirects();
    bus.stall = 1'b1;
    step("stall");
    check("rs1.fv", bus.fetch_valid, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_stall");
    @(negedge clk);
    rst_n = 1'b1;
    bus.stall = 1'b0;
    step("boot");
    check("rs1.boot_fv", bus.fetch_valid, 32'h1);

    // Run to the top of instruction memory
    bus.jr = 1'b1; bus.jr_addr = 32'd32752;
    step("jr");
    check("lim.pc", bus.pc, 32'd32752);
    clear_redirects();
    step("seq");
    step("seq");
    check("lim.pc_last", bus.pc, 32'd32760);
    check("lim.fv_last", bus.fetch_valid, 32'h1);
    step("halt");
    check("lim.halt", bus.halted, 32'h1);
    check("lim.pc_held", bus.pc, 32'd32760);
    check("lim.fv", bus.fetch_valid, 32'h0);
    check("lim.mis", bus.misalign_err, 32'h0);
    bus.stall = 1'b1; bus.jr = 1'b1; bus.jr_addr = 32'h0;
    step("halted");
    bus.stall = 1'b0;
    step("halted");
    check("hlt.pc", bus.pc, 32'd32760);
    check("hlt.halt", bus.halted, 32'h1);
    check("hlt.fv", bus.fetch_valid, 32'h0);

    // Async reset while halted
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_halt");
    @(negedge clk);
    rst_n = 1'b1;
    clear_redirects();
    step("boot");

    // Misaligned jr target
    bus.jr = 1'b1; bus.jr_addr = 32'h102;
    step("jr_misalign");
    check("mis.halt", bus.halted, 32'h1);
    check("mis.err", bus.misalign_err, 32'h1);
    check("mis.pc", bus.pc, 32'h0);
    check("mis.fv", bus.fetch_valid, 32'h0);
    clear_redirects();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns and sequences the MIPS program counter. Each cycle it selects the next PC from sequential, branch, jump and jump-register sources, and it freezes the PC on pipeline stalls. It handles the boot cycle after reset and halts permanently when the PC leaves instruction memory or a misaligned target is taken. It sits between the decode/hazard logic and the instruction memory address port, and replaces free-running PC update logic.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `PC_LIMIT`, default 32764: first address that is out of range. A computed next PC `>= PC_LIMIT` halts the sequencer.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `stall` input 1: hazard unit freeze request.
- `branch_taken` input 1: a conditional branch resolved taken.
- `branch_offset` input 32: sign-extended 16-bit immediate, in words.
- `jump` input 1: J/JAL.
- `jump_target` input 26: instr_index field.
- `jr` input 1: JR/JALR.
- `jr_addr` input 32: register value.
- `pc` output 32: current fetch address.
- `pc_plus4` output 32: `pc + 4`, for link and branch-base use.
- `fetch_valid` output 1: `pc` is a fetch to be executed this cycle.
- `halted` output 1: sticky halt.
- `misalign_err` output 1: sticky; the halt was caused by a target with bits [1:0] != 0.
- `instr_count` output 32: number of fetches issued, saturating.

## Operation
- States: BOOT, RUN, STALL, HALT. Encoding lives in the package.
- Reset (async, any time, including mid-redirect):
  - `pc=RESET_PC`, `pc_plus4=RESET_PC+4`.
  - `fetch_valid=0`, `halted=0`, `misalign_err=0`, `instr_count=0`.
  - state BOOT.
- BOOT: lasts exactly one cycle; `pc` is held; next state is RUN.
- RUN with `stall=0`:
  - `fetch_valid=1`; `instr_count` increments, saturating at 32'hFFFF_FFFF.
  - `pc` loads `next_pc`.
- `next_pc` priority is jr > jump > branch_taken > sequential:
  - jr: `jr_addr`.
  - jump: `{pc_plus4[31:28], jump_target, 2'b00}`.
  - branch: `pc_plus4 + (branch_offset << 2)`, modulo 2^32; wrap-around is not an error by itself.
  - sequential: `pc_plus4`.
- RUN with `stall=1`:
  - Go to STALL; `pc` is held; `fetch_valid=0`.
  - Any redirect presented in that cycle is ignored. The hazard unit re-presents it once stall drops.
- STALL: holds while `stall=1`; returns to RUN on `stall=0`. The update in that RUN cycle follows the RUN rules.
- Halt check applies to `next_pc` in RUN only. If `next_pc >= PC_LIMIT` (unsigned) or `next_pc[1:0] != 0`:
  - Go to HALT; `pc` is held at the last valid value; `fetch_valid=0`; `halted=1`.
  - `misalign_err=1` only if the cause is misalignment; misalignment is checked first.
- HALT: absorbing until `rst_n` is asserted. All inputs are ignored; `instr_count` is frozen.
- `pc_plus4` always equals `pc + 4` (mod 2^32).

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Redirect latency is one cycle: inputs sampled at edge N set `pc` visible after edge N.
- After `rst_n` deasserts:
  - First edge: BOOT → RUN.
  - `fetch_valid` rises after that first edge, with `pc=RESET_PC`.
  - Second edge: `pc` advances.
- `stall` takes effect on the edge it is sampled high; `pc` does not change on that edge.
- Simultaneous `stall` and halt-triggering `next_pc`: stall wins, and no halt occurs that cycle.
- Deasserting `rst_n` is synchronized externally. The block itself only requires async assertion.

## Structure
- Shared package `mips_fetch_pkg` holds:
  - state enum (BOOT, RUN, STALL, HALT);
  - next-PC select enum (SEQ, BR, J, JR);
  - constants `PC_INC=4` and default `PC_LIMIT`.
- One combinational sub-module, `pc_next_mux`:
  - inputs `pc_plus4` plus the redirect inputs;
  - outputs `next_pc`, select code, `out_of_range`, `misaligned`.
- The top level holds the FSM, the registers and the counter.

## Test plan
- Reset release, no redirects: `pc` sequence 0,0,4,8,12; `fetch_valid` 0,1,1,1,1; `instr_count`=4 after 5 edges.
- At `pc=0x40`, `branch_taken`=1 with `branch_offset=-4`: next `pc=0x34`. Same cycle with jump=1 and `jump_target=0x10`: `pc=0x40` (jump beats branch).
- Stall for 3 cycles at `pc=0x20`, with jr=1 and `jr_addr=0x100` held during the stall: `pc` stays 0x20, `fetch_valid=0` ×3. Then jr is sampled after stall drops: `pc=0x100`.
- Sequential run to `pc=32760`: next edge gives `halted=1`, `pc=32760`, `fetch_valid=0`, `misalign_err=0`. `stall` and jr afterwards change nothing.
- jr with `jr_addr=0x102`: `halted=1`, `misalign_err=1`, `pc` unchanged.
- Assert `rst_n` low mid-stall and mid-HALT: all outputs go to reset values immediately, without waiting for a clock edge.
